// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch interface, the stage and its bench.
package if_fetch_pkg;

  localparam int unsigned REG_W = 32;

  localparam logic [REG_W-1:0] RESET_PC_DEF =
    32'h1C00_0000;

  localparam logic [REG_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [REG_W-1:0] pc;
    logic [REG_W-1:0] inst;
  } if_id_t;

  function automatic logic [REG_W-1:0] align_pc(
    input logic [REG_W-1:0] a
  );
    return {a[REG_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// SRAM-like instruction port: req/addr_ok request
// phase, data_ok/rdata response phase.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic             req;
  logic [REG_W-1:0] addr;
  logic             addr_ok;
  logic             data_ok;
  logic [REG_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one request
// at a time and offers the fetched word to ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctl_id_allow_in_i,
  input  logic             br_taken_i,
  input  logic [REG_W-1:0] br_target_i,
  if_fetch_if.master       inst,
  output logic [REG_W-1:0] if_pc_o,
  output logic [REG_W-1:0] if_inst_o,
  output logic             ctl_if_over_o
);

  fetch_state_e     state;
  logic [REG_W-1:0] pc;
  logic [REG_W-1:0] inst_buf;
  logic             cancel;
  logic [REG_W-1:0] tgt;
  if_id_t           if_id;

  assign tgt = align_pc(br_target_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      inst_buf <= '0;
      cancel   <= 1'b0;
    end else begin
      unique case (state)
        FETCH_IDLE: state <= FETCH_REQ;
        FETCH_REQ: begin
          if (br_taken_i)
            pc <= tgt;
          if (inst.addr_ok) begin
            state <= FETCH_WAIT;
            // accepted address is now stale
            if (br_taken_i)
              cancel <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (inst.data_ok) begin
            if (cancel || br_taken_i) begin
              cancel <= 1'b0;
              state  <= FETCH_REQ;
              if (br_taken_i)
                pc <= tgt;
            end else begin
              inst_buf <= inst.rdata;
              state    <= FETCH_HOLD;
            end
          end else if (br_taken_i) begin
            pc     <= tgt;
            cancel <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          // redirect wins over the ID handshake
          if (br_taken_i) begin
            pc    <= tgt;
            state <= FETCH_REQ;
          end else if (ctl_id_allow_in_i) begin
            pc    <= pc + PC_STEP;
            state <= FETCH_REQ;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign inst.req  = (state == FETCH_REQ);
  assign inst.addr = pc;

  assign if_id.pc   = pc;
  assign if_id.inst = inst_buf;

  assign if_pc_o       = if_id.pc;
  assign if_inst_o     = if_id.inst;
  assign ctl_if_over_o = (state == FETCH_HOLD)
                      && !br_taken_i;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable
// instruction memory and an expected-transfer scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk;
  logic        rst;
  logic        allow;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        over;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ctl_id_allow_in_i (allow),
    .br_taken_i        (br),
    .br_target_i       (tgt),
    .inst              (bus),
    .if_pc_o           (pc_o),
    .if_inst_o         (inst_o),
    .ctl_if_over_o     (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int nxfer  = 0;
  int lat    = 0;

  if_id_t      expq[$];
  logic [31:0] addr_log[$];

  function automatic logic [31:0] mem(
    input logic [31:0] a
  );
    if (a == 32'h1C00_0004)
      return 32'h0280_0421;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    ntests++;
    nfail++;
    $error("FAIL %s: observed timeout expected event",
           tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a);
    if_id_t e;
    e.pc   = a;
    e.inst = mem(a);
    expq.push_back(e);
  endtask

  task automatic wait_xfer(input int n);
    int k;
    k = 0;
    while (nxfer < n && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (nxfer < n)
      tmo("wait_xfer");
    #2;
    allow = 1'b0;
  endtask

  task automatic wait_over();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!over && k < 60);
    if (!over)
      tmo("wait_over");
  endtask

  // ID side: every accepted transfer must match the queue head
  initial begin
    if_id_t e;
    forever begin
      @(negedge clk);
      if (over && allow) begin
        nxfer++;
        if (expq.size() == 0) begin
          chk("xfer_unexpected_pc", pc_o, 32'hxxxx_xxxx);
        end else begin
          e = expq.pop_front();
          chk("xfer_pc", pc_o, e.pc);
          chk("xfer_inst", inst_o, e.inst);
        end
      end
    end
  end

  // memory: response lat cycles after the accepting edge
  initial begin
    logic        hs;
    logic        done;
    logic        pend;
    logic [31:0] hs_addr;
    logic [31:0] paddr;
    int          hs_lat;
    int          cnt;
    pend         = 1'b0;
    paddr        = '0;
    cnt          = 0;
    bus.data_ok  = 1'b0;
    bus.rdata    = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      hs      = bus.req && bus.addr_ok;
      hs_addr = bus.addr;
      hs_lat  = lat;
      done    = bus.data_ok;
      @(posedge clk);
      #1;
      if (done)
        pend = 1'b0;
      if (hs) begin
        pend = 1'b1;
        paddr = hs_addr;
        cnt = hs_lat;
        addr_log.push_back(hs_addr);
      end else if (pend && cnt > 0) begin
        cnt--;
      end
      bus.data_ok = pend && (cnt == 0);
      bus.rdata   = pend ? mem(paddr) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    rst         = 1'b1;
    allow       = 1'b0;
    br          = 1'b0;
    tgt         = '0;
    bus.addr_ok = 1'b1;

    // reset values
    at_neg();
    at_neg();
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_over", {31'd0, over}, 32'd0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_inst", inst_o, 32'd0);
    rst = 1'b0;

    // back-to-back fetch, zero latency
    allow = 1'b1;
    push(32'h1C00_0000);
    push(32'h1C00_0004);
    push(32'h1C00_0008);
    wait_xfer(3);
    chk("log_size", addr_log.size(), 32'd3);
    chk("req0_addr", addr_log[0], 32'h1C00_0000);
    chk("req1_addr", addr_log[1], 32'h1C00_0004);
    chk("req2_addr", addr_log[2], 32'h1C00_0008);

    // redirect in HOLD with allow_in high
    wait_over();
    chk("hold_pc", pc_o, 32'h1C00_000C);
    tick();
    br    = 1'b1;
    tgt   = 32'h1C00_0004;
    allow = 1'b1;
    at_neg();
    chk("hold_br_over", {31'd0, over}, 32'd0);
    tick();
    br    = 1'b0;
    allow = 1'b0;
    at_neg();
    chk("hold_br_req", {31'd0, bus.req}, 32'd1);
    chk("hold_br_addr", bus.addr, 32'h1C00_0004);

    // stall in HOLD for five cycles
    push(32'h1C00_0004);
    wait_over();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", pc_o, 32'h1C00_0004);
      chk("stall_inst", inst_o, 32'h0280_0421);
      chk("stall_over", {31'd0, over}, 32'd1);
      at_neg();
    end
    tick();
    allow = 1'b1;
    wait_xfer(4);

    // redirect in WAIT, late response must be dropped
    wait_over();
    tick();
    lat = 2;
    br  = 1'b1;
    tgt = 32'h1C00_0200;
    at_neg();
    chk("w_over", {31'd0, over}, 32'd0);
    tick();
    br = 1'b0;
    at_neg();
    chk("w_addr", bus.addr, 32'h1C00_0200);
    tick();
    br    = 1'b1;
    tgt   = 32'h1C00_0100;
    lat   = 0;
    allow = 1'b1;
    at_neg();
    chk("w_req", {31'd0, bus.req}, 32'd0);
    tick();
    br = 1'b0;
    push(32'h1C00_0100);
    wait_xfer(5);

    // redirect coinciding with data_ok
    at_neg();
    tick();
    br  = 1'b1;
    tgt = 32'h1C00_0300;
    at_neg();
    chk("d_over", {31'd0, over}, 32'd0);
    chk("d_req", {31'd0, bus.req}, 32'd0);
    tick();
    br = 1'b0;
    at_neg();
    chk("d_req2", {31'd0, bus.req}, 32'd1);
    chk("d_addr", bus.addr, 32'h1C00_0300);
    push(32'h1C00_0300);
    allow = 1'b1;
    wait_xfer(6);

    // redirect with addr_ok in REQ, then PC wrap
    br  = 1'b1;
    tgt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0;
    at_neg();
    chk("r_req", {31'd0, bus.req}, 32'd0);
    tick();
    at_neg();
    chk("r_addr", bus.addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick();
    allow = 1'b1;
    wait_xfer(7);
    bus.addr_ok = 1'b0;
    at_neg();
    chk("wrap_req", {31'd0, bus.req}, 32'd1);
    chk("wrap_addr", bus.addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("nack_addr", bus.addr, 32'h0000_0000);
    end
    tick();
    br  = 1'b1;
    tgt = 32'h1C00_0102;
    tick();
    br = 1'b0;
    at_neg();
    chk("align_req", {31'd0, bus.req}, 32'd1);
    chk("align_addr", bus.addr, 32'h1C00_0100);
    tick();
    bus.addr_ok = 1'b1;
    allow       = 1'b1;
    push(32'h1C00_0100);
    wait_xfer(8);

    // reset mid-WAIT followed by a stray response
    lat = 3;
    at_neg();
    tick();
    rst         = 1'b1;
    bus.addr_ok = 1'b0;
    lat         = 0;
    #1;
    chk("mr_req", {31'd0, bus.req}, 32'd0);
    chk("mr_over", {31'd0, over}, 32'd0);
    chk("mr_pc", pc_o, RST_PC);
    chk("mr_inst", inst_o, 32'd0);
    at_neg();
    tick();
    at_neg();
    rst = 1'b0;
    tick();
    at_neg();
    chk("rs_req", {31'd0, bus.req}, 32'd1);
    chk("rs_addr", bus.addr, RST_PC);
    tick();
    at_neg();
    chk("stray_over", {31'd0, over}, 32'd0);
    chk("stray_inst", inst_o, 32'd0);
    chk("stray_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.addr_ok = 1'b1;
    allow       = 1'b1;
    push(RST_PC);
    wait_xfer(9);

    repeat (3) at_neg();
    chk("q_empty", expq.size(), 32'd0);
    chk("xfer_total", nxfer, 32'd9);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
